// File: rtl/ccff_chain_loader_if.sv
// Host-side bitstream bus for the config-chain loader: word write channel
// plus the readback word stream returned from the chain tail.
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [WORD_W-1:0] rd_data;
    logic              rd_valid;

    modport master (
        output cfg_data, cfg_valid,
        input  cfg_ready, rd_data, rd_valid
    );

    modport slave (
        input  cfg_data, cfg_valid,
        output cfg_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/ccff_chain_loader.sv
// Serialises host words LSB-first into one flop-based config chain and
// packs the bits leaving ccff_tail into readback words.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int WORD_W    = 8
) (
    input  logic               prog_clk,
    input  logic               prog_reset,
    input  logic               start,
    ccff_chain_loader_if.slave bus,
    output logic               ccff_head,
    input  logic               ccff_tail,
    output logic               shift_en,
    output logic               busy,
    output logic               done
);
    localparam int CNT_W   = $clog2(CHAIN_LEN + 1);
    localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int WA_W    = $clog2(N_WORDS + 1);
    localparam int SC_W    = $clog2(WORD_W + 1);

    typedef enum logic [1:0] {IDLE, FILL, SHIFT, DONE} state_t;

    state_t            state, nxt_state;
    logic [CNT_W-1:0]  bits_left, nxt_bits_left;
    logic [WA_W-1:0]   words_acc, nxt_words_acc;
    logic [WORD_W-1:0] sreg, nxt_sreg;
    logic [SC_W-1:0]   sreg_cnt, nxt_sreg_cnt;
    logic [WORD_W-1:0] buf_q, nxt_buf;
    logic              buf_full, nxt_buf_full;
    logic [WORD_W-1:0] rb_sreg, nxt_rb_sreg, rb_word;
    logic [SC_W-1:0]   rb_cnt, nxt_rb_cnt;
    logic [WORD_W-1:0] rd_data_q, nxt_rd_data;
    logic              rd_valid_q, nxt_rd_valid;
    logic              nxt_busy, nxt_done;
    logic              accept, sreg_drained, last_bit;

    assign bus.cfg_ready = busy & ~buf_full & (words_acc < WA_W'(N_WORDS));
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_valid  = rd_valid_q;
    assign accept        = bus.cfg_valid & bus.cfg_ready;

    always_comb begin
        nxt_state     = state;
        nxt_bits_left = bits_left;
        nxt_words_acc = words_acc;
        nxt_sreg      = sreg;
        nxt_sreg_cnt  = sreg_cnt;
        nxt_buf       = buf_q;
        nxt_buf_full  = buf_full;
        nxt_rb_sreg   = rb_sreg;
        nxt_rb_cnt    = rb_cnt;
        nxt_rd_data   = rd_data_q;
        nxt_rd_valid  = 1'b0;
        nxt_busy      = busy;
        nxt_done      = done;
        sreg_drained  = 1'b0;
        last_bit      = 1'b0;

        // Tail bit lands at its readback position; high bits stay zero for a short last word.
        rb_word = rb_sreg;
        for (int i = 0; i < WORD_W; i++) begin
            if (SC_W'(i) == rb_cnt) rb_word[i] = ccff_tail;
        end

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    nxt_state     = FILL;
                    nxt_busy      = 1'b1;
                    nxt_done      = 1'b0;
                    nxt_bits_left = CNT_W'(CHAIN_LEN);
                    nxt_words_acc = '0;
                    nxt_sreg      = '0;
                    nxt_sreg_cnt  = '0;
                    nxt_buf       = '0;
                    nxt_buf_full  = 1'b0;
                    nxt_rb_sreg   = '0;
                    nxt_rb_cnt    = '0;
                end
            end
            FILL, SHIFT: begin
                if (accept) nxt_words_acc = words_acc + WA_W'(1);
                if (state == SHIFT) begin
                    nxt_sreg      = sreg >> 1;
                    nxt_sreg_cnt  = sreg_cnt - SC_W'(1);
                    nxt_bits_left = bits_left - CNT_W'(1);
                    last_bit      = (bits_left == CNT_W'(1));
                    sreg_drained  = (sreg_cnt == SC_W'(1));
                    if (rb_cnt == SC_W'(WORD_W - 1) || last_bit) begin
                        nxt_rd_valid = 1'b1;
                        nxt_rd_data  = rb_word;
                        nxt_rb_sreg  = '0;
                        nxt_rb_cnt   = '0;
                    end else begin
                        nxt_rb_sreg = rb_word;
                        nxt_rb_cnt  = rb_cnt + SC_W'(1);
                    end
                end else begin
                    sreg_drained = 1'b1;
                end

                if (last_bit) begin
                    nxt_state = DONE;
                    nxt_busy  = 1'b0;
                    nxt_done  = 1'b1;
                end else if (sreg_drained) begin
                    // Refill on the same edge the last bit leaves, so no bubble when data is waiting.
                    if (buf_full) begin
                        nxt_sreg     = buf_q;
                        nxt_sreg_cnt = SC_W'(WORD_W);
                        nxt_buf_full = 1'b0;
                        nxt_state    = SHIFT;
                    end else if (accept) begin
                        nxt_sreg     = bus.cfg_data;
                        nxt_sreg_cnt = SC_W'(WORD_W);
                        nxt_state    = SHIFT;
                    end else begin
                        nxt_state = FILL;
                    end
                end else if (accept) begin
                    nxt_buf      = bus.cfg_data;
                    nxt_buf_full = 1'b1;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge prog_clk or posedge prog_reset) begin
        if (prog_reset) begin
            state      <= IDLE;
            bits_left  <= '0;
            words_acc  <= '0;
            sreg       <= '0;
            sreg_cnt   <= '0;
            buf_q      <= '0;
            buf_full   <= 1'b0;
            rb_sreg    <= '0;
            rb_cnt     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            shift_en   <= 1'b0;
            ccff_head  <= 1'b0;
        end else begin
            state      <= nxt_state;
            bits_left  <= nxt_bits_left;
            words_acc  <= nxt_words_acc;
            sreg       <= nxt_sreg;
            sreg_cnt   <= nxt_sreg_cnt;
            buf_q      <= nxt_buf;
            buf_full   <= nxt_buf_full;
            rb_sreg    <= nxt_rb_sreg;
            rb_cnt     <= nxt_rb_cnt;
            rd_data_q  <= nxt_rd_data;
            rd_valid_q <= nxt_rd_valid;
            busy       <= nxt_busy;
            done       <= nxt_done;
            shift_en   <= (nxt_state == SHIFT);
            ccff_head  <= (nxt_state == SHIFT) & nxt_sreg[0];
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 10-flop chain model plus a bit-queue
// reference of head/readback streams, directed cases and random loads.
module tb_ccff_chain_loader;
    localparam int L  = 10;
    localparam int WW = 4;
    localparam int NW = (L + WW - 1) / WW;

    logic prog_clk = 1'b0;
    logic prog_reset = 1'b1;
    logic start = 1'b0;
    logic ccff_head, ccff_tail, shift_en, busy, done;

    ccff_chain_loader_if #(.WORD_W(WW)) bus ();

    ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(WW)) dut (
        .prog_clk  (prog_clk),
        .prog_reset(prog_reset),
        .start     (start),
        .bus       (bus),
        .ccff_head (ccff_head),
        .ccff_tail (ccff_tail),
        .shift_en  (shift_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 prog_clk = ~prog_clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Fabric chain: shifts only on enabled edges, is not cleared by the loader reset.
    logic [L-1:0] chain = '0;
    assign ccff_tail = chain[L-1];
    always @(posedge prog_clk) if (shift_en) chain <= {chain[L-2:0], ccff_head};

    bit              head_q[$];
    logic [WW-1:0]   rd_q[$];
    int              shifts = 0, acc = 0, pushed = 0, rd_n = 0;
    bit              in_load = 0, fin_pending = 0, abort = 0;
    logic [L-1:0]    head_log = '0;
    logic [WW-1:0]   rd_log[8];
    logic [WW-1:0]   exp_w;
    bit              exp_b;

    function automatic void build_rd();
        logic [WW-1:0] w = '0;
        int k = 0;
        rd_q.delete();
        for (int i = 0; i < L; i++) begin
            w[k] = chain[L-1-i];
            k++;
            if (k == WW || i == L - 1) begin
                rd_q.push_back(w);
                w = '0;
                k = 0;
            end
        end
    endfunction

    always @(negedge prog_clk) begin
        if (prog_reset) begin
            chk("rst_shift_en", shift_en, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_rd_valid", bus.rd_valid, 0);
            chk("rst_cfg_ready", bus.cfg_ready, 0);
            chk("rst_head", ccff_head, 0);
            head_q.delete();
            rd_q.delete();
            in_load = 0;
            fin_pending = 0;
        end else begin
            if (fin_pending) begin
                chk("done_after_last", done, 1);
                chk("busy_after_last", busy, 0);
                chk("shift_after_last", shift_en, 0);
                fin_pending = 0;
            end
            if (bus.rd_valid) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    exp_w = rd_q.pop_front();
                    chk("rd_data", bus.rd_data, exp_w);
                end
                if (rd_n < 8) rd_log[rd_n] = bus.rd_data;
                rd_n++;
            end
            if (shift_en) begin
                if (!in_load || head_q.size() == 0) chk("shift_without_bit", 1, 0);
                else begin
                    exp_b = head_q.pop_front();
                    chk("ccff_head", ccff_head, exp_b);
                    head_log[shifts] = ccff_head;
                    shifts++;
                    if (shifts == L) begin
                        fin_pending = 1;
                        in_load = 0;
                    end
                end
            end
            if (bus.cfg_ready && acc >= NW) chk("ready_beyond_words", 1, 0);
            if (bus.cfg_valid && bus.cfg_ready) begin
                for (int b = 0; b < WW; b++) begin
                    if (pushed < L) begin
                        head_q.push_back(bus.cfg_data[b]);
                        pushed++;
                    end
                end
                acc++;
            end
            if (start && !busy) begin
                shifts = 0; acc = 0; pushed = 0; rd_n = 0;
                head_log = '0;
                head_q.delete();
                build_rd();
                in_load = 1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge prog_clk); #1;
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [WW-1:0] w, input int gap);
        bit rdy;
        int n = 0;
        bus.cfg_valid = 1'b0;
        for (int g = 0; g < gap && !abort; g++) begin
            @(posedge prog_clk); #1;
        end
        if (abort) return;
        bus.cfg_data  = w;
        bus.cfg_valid = 1'b1;
        forever begin
            @(negedge prog_clk);
            rdy = bus.cfg_ready;
            @(posedge prog_clk); #1;
            if (rdy || abort) break;
            n++;
            if (n > 200) begin
                chk("cfg_ready_timeout", 0, 1);
                break;
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        forever begin
            @(negedge prog_clk);
            if (done && !busy) break;
            n++;
            if (n > 300) begin
                chk("done_timeout", 0, 1);
                break;
            end
        end
        @(posedge prog_clk); #1;
    endtask

    task automatic do_load(input logic [WW-1:0] w0, w1, w2, input int g0, g1, g2, input int inj);
        pulse_start();
        fork
            begin
                send(w0, g0); send(w1, g1); send(w2, g2);
            end
            begin
                if (inj > 0) begin
                    repeat (inj) @(posedge prog_clk);
                    #1 start = 1'b1;
                    @(posedge prog_clk); #1;
                    start = 1'b0;
                end
            end
        join
        wait_done();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_shift_en"}, shift_en, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_cfg_ready"}, bus.cfg_ready, 0);
        chk({tag, "_rd_valid"}, bus.rd_valid, 0);
        chk({tag, "_head"}, ccff_head, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cfg_data  = '0;
        bus.cfg_valid = 1'b0;
        repeat (3) @(posedge prog_clk);
        #2 prog_reset = 1'b0;
        repeat (2) @(posedge prog_clk);

        // Asynchronous reset while idle.
        #2 prog_reset = 1'b1;
        #1 check_idle_outputs("idle_rst");
        @(posedge prog_clk); #2 prog_reset = 1'b0;

        // Basic load.
        do_load(4'h5, 4'hA, 4'h3, 0, 0, 0, 0);
        chk("basic_shifts", shifts, L);
        chk("basic_head_seq", head_log, 10'h3A5);
        chk("basic_done", done, 1);
        chk("basic_busy", busy, 0);
        bus.cfg_data = 4'h7; bus.cfg_valid = 1'b1;
        @(negedge prog_clk);
        chk("fourth_word_ready", bus.cfg_ready, 0);
        @(posedge prog_clk); #1 bus.cfg_valid = 1'b0;

        // Readback of the basic load's contents.
        do_load(4'hF, 4'hF, 4'hF, 0, 0, 0, 0);
        chk("rb_count", rd_n, 3);
        chk("rb_word0", rd_log[0], 4'h5);
        chk("rb_word1", rd_log[1], 4'hA);
        chk("rb_word2", rd_log[2], 4'h3);
        chk("rb_head_seq", head_log, 10'h3FF);

        // Stall after the first word.
        do_load(4'h5, 4'hA, 4'h3, 0, 3, 0, 0);
        chk("stall_shifts", shifts, L);
        chk("stall_head_seq", head_log, 10'h3A5);
        chk("stall_rb_word0", rd_log[0], 4'hF);
        chk("stall_rb_word2", rd_log[2], 4'h3);

        // Start pulsed mid-load is ignored.
        do_load(4'hC, 4'h6, 4'h9, 0, 1, 0, 5);
        chk("ign_shifts", shifts, L);
        chk("ign_head_seq", head_log, {2'b01, 4'h6, 4'hC});

        // Abort after six shifts, then a fresh load.
        pulse_start();
        fork
            begin
                send(4'h1, 0); send(4'h2, 0); send(4'h4, 0);
            end
            begin
                int n = 0;
                while (shifts < 6 && n < 100) begin
                    @(posedge prog_clk); #2;
                    n++;
                end
                chk("abort_reached_six", shifts >= 6, 1);
                prog_reset = 1'b1;
                abort = 1;
                #1 check_idle_outputs("abort_rst");
            end
        join
        @(posedge prog_clk); #2;
        prog_reset = 1'b0;
        abort = 0;
        repeat (3) @(negedge prog_clk);
        chk("post_abort_shift_en", shift_en, 0);
        do_load(4'h8, 4'h3, 4'h2, 1, 0, 2, 0);
        chk("fresh_shifts", shifts, L);
        chk("fresh_head_seq", head_log, {2'b10, 4'h3, 4'h8});
        chk("fresh_rb_count", rd_n, 3);

        // Random loads with random gaps and stray start pulses.
        for (int r = 0; r < 10; r++) begin
            logic [WW-1:0] rw0, rw1, rw2;
            rw0 = WW'($urandom_range(0, 15));
            rw1 = WW'($urandom_range(0, 15));
            rw2 = WW'($urandom_range(0, 15));
            do_load(rw0, rw1, rw2, $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 8));
            chk("rand_shifts", shifts, L);
            chk("rand_head_seq", head_log, {rw2[1:0], rw1, rw0});
            chk("rand_rb_count", rd_n, 3);
        end

        repeat (2) @(posedge prog_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Sequences configuration-chain programming.
- Accepts bitstream words from the configuration host over a valid/ready handshake and serialises them LSB-first onto the ccff_head of one flop-based config chain of known length.
- Emits a per-bit shift enable that the fabric-level prog_clk gate uses. Only those cycles advance the chain.
- Returns the bits shifted out of ccff_tail as readback words, so the host can verify the previous chain contents.

Parameters:
- CHAIN_LEN, 64: number of config flops in the chain, >=1. Exactly this many shift cycles per load.
- WORD_W, 8: host word width, >=1.
- CNT_W, clog2(CHAIN_LEN+1): derived. Width of the bit counter. Not to be overridden.

Ports:
- prog_clk  in  1  programming clock. All logic is on the rising edge.
- prog_reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load. Ignored while busy=1.
- cfg_data  in  WORD_W  bitstream word. Bit 0 is shifted first.
- cfg_valid  in  1  cfg_data valid.
- cfg_ready  out  1  word accepted on an edge where cfg_valid&cfg_ready.
- ccff_head  out  1  serial bit into the chain. Meaningful when shift_en=1.
- ccff_tail  in  1  chain output, sampled on edges where shift_en=1.
- shift_en  out  1  the chain captures ccff_head on the next prog_clk edge.
- busy  out  1  load in progress.
- done  out  1  last load completed. Held until the next accepted start.
- rd_data  out  WORD_W  readback word, bit 0 = first bit shifted out.
- rd_valid  out  1  one-cycle pulse. No backpressure.

Behaviour:
- Clock/reset: one clock, prog_clk; prog_reset is asynchronous, active-high.
- Reset values: all outputs 0. FSM=IDLE. Counters, holding buffer and shift registers cleared.
- Reset mid-load: the load aborts immediately. Chain contents are undefined and the host must restart.
- FSM states: IDLE, FILL, SHIFT, DONE.
- IDLE/DONE with start=1 -> FILL. This sets busy=1, clears done, and sets bits_left=CHAIN_LEN.
- Buffering: one holding buffer plus a WORD_W shift register.
  - cfg_ready = busy & ~buf_full & (words accepted < ceil(CHAIN_LEN/WORD_W)).
  - Words beyond that count are never accepted.
- FILL: wait for the shift register to hold a word, then move to SHIFT.
  - A word accepted at edge t is in the shift register and driving shift_en=1 in the cycle after t.
- SHIFT, each cycle with a bit available:
  - shift_en=1 and ccff_head=sreg[0].
  - On the edge: sreg shifts right, ccff_tail enters the readback shifter, bits_left decrements.
- Word boundary: when the shift register empties and the buffer is full, the buffer word moves in on the same edge, so there is no bubble. If the buffer is empty, go to FILL and hold shift_en=0. Counts are preserved across stalls.
- Partial final word: when CHAIN_LEN mod WORD_W != 0, only the low (CHAIN_LEN mod WORD_W) bits of the last word are shifted. The rest are discarded.
- Readback:
  - rd_valid pulses the cycle after every WORD_W-th captured bit.
  - It also pulses after the final bit, with the partial word zero-padded in the high bits.
- Completion: on the edge where bits_left goes 1->0, go to DONE. On the next cycle shift_en=0, busy=0 and done=1.
- Simultaneous events:
  - start while busy=1 is ignored.
  - start in DONE on the same edge as the final rd_valid: rd_valid still pulses, and the new load begins.
- Invariant: shift_en is never 1 outside SHIFT. The total number of shift_en cycles per load is exactly CHAIN_LEN.

Test Plan:
- Reset check: assert prog_reset mid-idle and mid-SHIFT -> all outputs are 0 asynchronously, with no shift_en glitch after release.
- Basic load (CHAIN_LEN=10, WORD_W=4): start, then words 0x5, 0xA, 0x3 back-to-back ->
  - 10 consecutive shift_en cycles, with ccff_head = 1,0,1,0,0,1,0,1,1,1.
  - Bits 3:2 of 0x3 are dropped.
  - Then done=1, busy=0, and cfg_ready=0 for a 4th word.
- Stall: same load with a 3-cycle cfg_valid gap after 0x5 -> shift_en=0 during the gap, no duplicated or skipped bits, still exactly 10 shifts.
- Readback: chain model preloaded by the basic load, then a second load of 0xF,0xF,0xF -> rd_data = 0x5, 0xA, 0x3 (the last one zero-padded), with rd_valid pulsing 3 times.
- Ignored start: pulse start during SHIFT -> no restart, and bits_left/shift sequence are unchanged.
- Abort: assert prog_reset after 6 shifts, then start a fresh load -> exactly 10 new shifts and correct done timing.
